data_memory_responder: RTL and testbench
========================================

# data_memory_responder

Responder end of the CPU data-memory interface. It accepts one load or store request at a time from the MEM stage, holds it for a programmable number of wait states, and then returns a response that the CPU must acknowledge. It replaces the zero-latency data memory, so the pipeline can be exercised against realistic memory timing. It holds its own word-organised storage, and out-of-range accesses are flagged on the response.

## Interface
Parameters:
- DEPTH, 4096, number of 32-bit words stored; power of two; ADDR_W = log2(DEPTH) (12 at default).
- LATENCY, 2, wait states between accept and response, range 0..15.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  CPU presents a request.
- req_ready  out  1  responder accepts a request this cycle; equals (state == IDLE).
- req_store  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address; word index = req_addr[ADDR_W+1:2].
- req_wdata  in  32  store data.
- req_wstrb  in  4  byte-lane write enables for stores; ignored for loads.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  CPU consumes the response.
- rsp_rdata  out  32  load data; 0 for stores and for errors.
- rsp_error  out  1  the access was out of range.

## Operation
- States: IDLE, WAIT, RESP.
- **IDLE**
  - req_ready = 1.
  - On req_valid, the request is accepted. At that edge, capture req_store, word index, req_wdata and req_wstrb.
  - Set the error flag when req_addr[31:ADDR_W+2] != 0. req_addr[1:0] is ignored.
  - Next state is WAIT with cnt = LATENCY, or RESP directly when LATENCY = 0.
- **WAIT**
  - cnt (4 bits) decrements each cycle.
  - When cnt == 1, the next state is RESP.
  - req_ready = 0 and new requests are not sampled.
- **Entering RESP** (access edge), the memory is accessed exactly once:
  - Store without error: write the lanes whose req_wstrb bit is set, byte i to bits [8i+7:8i]. req_wstrb = 0 is a legal no-op. rsp_rdata = 0.
  - Load without error: rsp_rdata = stored word.
  - Error: no write, rsp_rdata = 0, rsp_error = 1.
- **RESP**
  - rsp_valid = 1. rsp_rdata and rsp_error stay stable until the handshake.
  - On rsp_valid && rsp_ready, go to IDLE, with rsp_valid = 0 on the next cycle.
  - req_ready = 0 throughout RESP, so no new request is accepted in the handshake cycle.
- **Ordering**
  - One outstanding request. Responses arrive in request order.
  - A load that follows a store to the same word returns the stored data.
- **Reset**
  - Outputs after reset: state IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_error = 0, cnt = 0.
  - Reset during WAIT abandons the request. A pending store is not written.
  - Reset during RESP drops the response. A store already committed remains.
  - Memory contents are not reset.
- req_wdata and req_wstrb are don't-care outside the accept cycle.

## Timing
- Accept edge N; rsp_valid is first high in cycle N+1+LATENCY.
- LATENCY = 0 gives a response in the cycle after the accept.
- A response held k cycles by rsp_ready = 0 delays the next accept by k cycles.
- Minimum spacing between accepts: LATENCY + 2 cycles, with rsp_ready tied high.
- The storage read is synchronous, on the access edge. There is no combinational path from req_* to rsp_*.

## Structure
- Shared package mem_pkg:
  - data32_t, strb_t (logic [3:0]).
  - Enum resp_state_t {IDLE, WAIT, RESP}.
  - Localparam CNT_W = 4.
- ADDR_W stays a module-local localparam derived from DEPTH.
- One sub-module, word_sram: single-port memory of DEPTH × 32 with byte-write enables and a synchronous read. It is instantiated once; the FSM and counter live in data_memory_responder.

## Test plan
- **Reset then idle:** assert rst for 2 cycles mid-WAIT, after a store to 0x40. Required: req_ready = 1, rsp_valid = 0, and a later load of 0x40 returns the prior value (store dropped).
- **Store/load, LATENCY = 2:** store 0xDEADBEEF to 0x100 with wstrb = 0xF, accepted at edge N. Required: rsp_valid at N+3, rsp_rdata = 0. A following load of 0x100 returns 0xDEADBEEF.
- **Byte strobes:** word 0x100 = 0xDEADBEEF; store 0x11223344 with wstrb = 0b0101, then load. Required: 0xDE22BE44.
- **Back-pressure:** hold rsp_ready = 0 for 5 cycles in RESP. Required: rsp_valid, rsp_rdata and rsp_error stay stable, req_ready = 0 throughout, and the next accept comes one cycle after the handshake.
- **Out of range, DEPTH = 4096:** load 0x00004000. Required: rsp_error = 1, rsp_rdata = 0. A store to 0x00004000 also flags rsp_error = 1 and leaves word 0 unchanged.
- **LATENCY = 0 and 15:** back-to-back loads with rsp_ready = 1. Required: responses at N+1 and N+16, and accepts spaced 2 and 17 cycles apart.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the data-memory responder and its storage array.
package mem_pkg;

    typedef logic [31:0] data32_t;
    typedef logic [3:0]  strb_t;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} resp_state_t;

    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/word_sram.sv
// Single-port word memory with byte-lane write enables and a synchronous read.
module word_sram
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH  = 4096,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              en,
    input  strb_t             we,
    input  logic [ADDR_W-1:0] addr,
    input  data32_t           wdata,
    output data32_t           rdata
);

    data32_t mem [DEPTH];

    // Read returns the word as it was before this edge's write.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_memory_responder.sv
// Responder for CPU data-memory requests: one outstanding access, programmable wait states.
module data_memory_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH   = 4096,
    parameter int unsigned LATENCY = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    req_valid,
    output logic    req_ready,
    input  logic    req_store,
    input  data32_t req_addr,
    input  data32_t req_wdata,
    input  strb_t   req_wstrb,
    output logic    rsp_valid,
    input  logic    rsp_ready,
    output data32_t rsp_rdata,
    output logic    rsp_error
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] LAT_CNT = LATENCY[CNT_W-1:0];

    resp_state_t       state;
    logic [CNT_W-1:0]  cnt;
    logic              store_q;
    logic              err_q;
    logic [ADDR_W-1:0] idx_q;
    data32_t           wdata_q;
    strb_t             wstrb_q;

    logic              req_err;
    logic              access;
    logic              mem_store;
    logic              mem_err;
    logic [ADDR_W-1:0] mem_idx;
    data32_t           mem_wdata;
    strb_t             mem_wstrb;
    strb_t             mem_we;
    data32_t           mem_rdata;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^req_addr[1:0];
    assign req_err = |req_addr[31:ADDR_W+2];

    // With zero latency the access edge is the accept edge, so use the live request.
    assign access = !rst && ((state == IDLE && req_valid && LATENCY == 0) ||
                             (state == WAIT && cnt == 1));

    always_comb begin
        mem_store = store_q;
        mem_err   = err_q;
        mem_idx   = idx_q;
        mem_wdata = wdata_q;
        mem_wstrb = wstrb_q;
        if (state == IDLE) begin
            mem_store = req_store;
            mem_err   = req_err;
            mem_idx   = req_addr[ADDR_W+1:2];
            mem_wdata = req_wdata;
            mem_wstrb = req_wstrb;
        end
    end

    assign mem_we = (mem_store && !mem_err) ? mem_wstrb : '0;

    word_sram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_word_sram (
        .clk   (clk),
        .en    (access),
        .we    (mem_we),
        .addr  (mem_idx),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            store_q <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        store_q <= req_store;
                        err_q   <= req_err;
                        idx_q   <= req_addr[ADDR_W+1:2];
                        wdata_q <= req_wdata;
                        wstrb_q <= req_wstrb;
                        if (LATENCY == 0) begin
                            state <= RESP;
                            cnt   <= '0;
                        end else begin
                            state <= WAIT;
                            cnt   <= LAT_CNT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == 1) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_error = (state == RESP) && err_q;
    assign rsp_rdata = (state == RESP && !store_q && !err_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder at latencies 2, 0 and 15.
module tb_data_memory_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_store;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_ready;

    logic        rdy2, rdy0, rdy15;
    logic        v2, v0, v15;
    logic        e2, e0, e15;
    logic [31:0] d2, d0, d15;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_memory_responder #(.DEPTH(4096), .LATENCY(2)) u_dut_l2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy2), .req_store(req_store),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .rsp_valid(v2),
        .rsp_ready(rsp_ready), .rsp_rdata(d2), .rsp_error(e2)
    );

    data_memory_responder #(.DEPTH(4096), .LATENCY(0)) u_dut_l0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy0), .req_store(req_store),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .rsp_valid(v0),
        .rsp_ready(rsp_ready), .rsp_rdata(d0), .rsp_error(e0)
    );

    data_memory_responder #(.DEPTH(4096), .LATENCY(15)) u_dut_l15 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy15), .req_store(req_store),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .rsp_valid(v15),
        .rsp_ready(rsp_ready), .rsp_rdata(d15), .rsp_error(e15)
    );

    // Instance select: 0 -> LATENCY 2, 1 -> LATENCY 0, 2 -> LATENCY 15.
    function automatic logic sel_ready(input int s);
        case (s)
            0:       return rdy2;
            1:       return rdy0;
            default: return rdy15;
        endcase
    endfunction

    function automatic logic sel_valid(input int s);
        case (s)
            0:       return v2;
            1:       return v0;
            default: return v15;
        endcase
    endfunction

    function automatic logic [31:0] sel_data(input int s);
        case (s)
            0:       return d2;
            1:       return d0;
            default: return d15;
        endcase
    endfunction

    function automatic logic sel_err(input int s);
        case (s)
            0:       return e2;
            1:       return e0;
            default: return e15;
        endcase
    endfunction

    // Call just after a falling edge; returns #1 after the accept edge.
    task automatic issue(input int s, input logic st, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] w, output int acc);
        int n = 0;
        acc = -1;
        req_valid = 1'b1;
        req_store = st;
        req_addr  = a;
        req_wdata = d;
        req_wstrb = w;
        while (!sel_ready(s) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL accept_timeout sel=%0d got req_ready=0 want 1", s);
        end else begin
            @(posedge clk);
            #1;
            acc = cyc;
        end
        req_valid = 1'b0;
    endtask

    // Returns at the falling edge of the first cycle with rsp_valid high.
    task automatic wait_rsp(input int s, output logic [31:0] d, output logic e, output int rc);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sel_valid(s) && n < 100);
        checks++;
        if (!sel_valid(s)) begin
            errors++;
            $display("FAIL rsp_timeout sel=%0d got rsp_valid=0 want 1", s);
        end
        d  = sel_data(s);
        e  = sel_err(s);
        rc = cyc + 1;
    endtask

    task automatic test_reset();
        int acc, rc;
        logic [31:0] d;
        logic e;
        rst = 1'b1;
        req_valid = 1'b0;
        req_store = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({rdy2, v2, e2, d2} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b vld=%b err=%b rdata=%h want 1 0 0 0",
                     rdy2, v2, e2, d2);
        end
        issue(0, 1'b1, 32'h40, 32'hA5A5A5A5, 4'hF, acc);
        wait_rsp(0, d, e, rc);
        issue(0, 1'b1, 32'h40, 32'h12345678, 4'hF, acc);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({rdy2, v2} !== 2'b10) begin
            errors++;
            $display("FAIL reset_mid_wait got rdy=%b vld=%b want 1 0", rdy2, v2);
        end
        issue(0, 1'b0, 32'h40, 32'h0, 4'h0, acc);
        wait_rsp(0, d, e, rc);
        checks++;
        if (d !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL reset_store_dropped got %h want a5a5a5a5", d);
        end
    endtask

    task automatic test_store_load();
        int acc, rc;
        logic [31:0] d;
        logic e;
        issue(0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, acc);
        wait_rsp(0, d, e, rc);
        checks++;
        if ({rc, d, e} !== {acc + 3, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL store_rsp got cyc=%0d rdata=%h err=%b want cyc=%0d 0 0",
                     rc, d, e, acc + 3);
        end
        issue(0, 1'b0, 32'h100, 32'h0, 4'h0, acc);
        wait_rsp(0, d, e, rc);
        checks++;
        if ({rc, d, e} !== {acc + 3, 32'hDEADBEEF, 1'b0}) begin
            errors++;
            $display("FAIL load_rsp got cyc=%0d rdata=%h err=%b want cyc=%0d deadbeef 0",
                     rc, d, e, acc + 3);
        end
    endtask

    task automatic test_byte_strobes();
        int acc, rc;
        logic [31:0] d;
        logic e;
        issue(0, 1'b1, 32'h100, 32'h11223344, 4'b0101, acc);
        wait_rsp(0, d, e, rc);
        issue(0, 1'b0, 32'h100, 32'h0, 4'h0, acc);
        wait_rsp(0, d, e, rc);
        checks++;
        if (d !== 32'hDE22BE44) begin
            errors++;
            $display("FAIL byte_strobes got %h want de22be44", d);
        end
    endtask

    task automatic test_back_pressure();
        int acc, rc, hs;
        logic [31:0] d, dh;
        logic e, eh;
        issue(0, 1'b0, 32'h100, 32'h0, 4'h0, acc);
        rsp_ready = 1'b0;
        wait_rsp(0, dh, eh, rc);
        checks++;
        if ({dh, eh} !== {32'hDE22BE44, 1'b0}) begin
            errors++;
            $display("FAIL bp_data got %h err=%b want de22be44 0", dh, eh);
        end
        // A competing request stays asserted while the response is stalled.
        req_valid = 1'b1;
        req_store = 1'b0;
        req_addr  = 32'h40;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({v2, d2, e2, rdy2} !== {1'b1, dh, eh, 1'b0}) begin
                errors++;
                $display("FAIL bp_hold_%0d got vld=%b rdata=%h err=%b rdy=%b want 1 %h %b 0",
                         i, v2, d2, e2, rdy2, dh, eh);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        hs = cyc + 1;
        issue(0, 1'b0, 32'h40, 32'h0, 4'h0, acc);
        checks++;
        if (acc !== hs + 1) begin
            errors++;
            $display("FAIL bp_next_accept got edge %0d want %0d", acc, hs + 1);
        end
        wait_rsp(0, d, e, rc);
        checks++;
        if (d !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL bp_next_data got %h want a5a5a5a5", d);
        end
    endtask

    task automatic test_out_of_range();
        int acc, rc;
        logic [31:0] d;
        logic e;
        issue(0, 1'b1, 32'h0, 32'h0BADF00D, 4'hF, acc);
        wait_rsp(0, d, e, rc);
        issue(0, 1'b0, 32'h4000, 32'h0, 4'h0, acc);
        wait_rsp(0, d, e, rc);
        checks++;
        if ({d, e} !== {32'h0, 1'b1}) begin
            errors++;
            $display("FAIL oor_load got rdata=%h err=%b want 0 1", d, e);
        end
        issue(0, 1'b1, 32'h4000, 32'hFFFFFFFF, 4'hF, acc);
        wait_rsp(0, d, e, rc);
        checks++;
        if ({d, e} !== {32'h0, 1'b1}) begin
            errors++;
            $display("FAIL oor_store got rdata=%h err=%b want 0 1", d, e);
        end
        issue(0, 1'b0, 32'h0, 32'h0, 4'h0, acc);
        wait_rsp(0, d, e, rc);
        checks++;
        if ({d, e} !== {32'h0BADF00D, 1'b0}) begin
            errors++;
            $display("FAIL oor_word0_kept got rdata=%h err=%b want 0badf00d 0", d, e);
        end
    endtask

    task automatic test_latency(input int s, input int lat);
        int acc1, acc2, rc;
        logic [31:0] d;
        logic e;
        issue(s, 1'b0, 32'h0, 32'h0, 4'h0, acc1);
        wait_rsp(s, d, e, rc);
        checks++;
        if (rc !== acc1 + 1 + lat) begin
            errors++;
            $display("FAIL lat%0d_first got cyc=%0d want %0d", lat, rc, acc1 + 1 + lat);
        end
        issue(s, 1'b0, 32'h4, 32'h0, 4'h0, acc2);
        checks++;
        if (acc2 - acc1 !== lat + 2) begin
            errors++;
            $display("FAIL lat%0d_spacing got %0d want %0d", lat, acc2 - acc1, lat + 2);
        end
        wait_rsp(s, d, e, rc);
        checks++;
        if (rc !== acc2 + 1 + lat) begin
            errors++;
            $display("FAIL lat%0d_second got cyc=%0d want %0d", lat, rc, acc2 + 1 + lat);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_byte_strobes();
        test_back_pressure();
        test_out_of_range();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_latency(1, 0);
        test_latency(2, 15);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
